// File: rtl/mips_prog_loader.sv
// Boot loader for pipe_MIPS32: parses a framed byte stream, writes 32-bit words
// into CPU memory and releases the CPU only after the frame checksum matches.
module mips_prog_loader #(
  parameter int          ADDR_W    = 10,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_run,
  output logic              busy,
  output logic              load_done,
  output logic              load_err,
  output logic [15:0]       words_loaded
);

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_DATA, S_CKS, S_RUN} state_t;

  state_t              state_q, state_d;
  logic [1:0]          hcnt_q, hcnt_d;
  logic [1:0]          bcnt_q, bcnt_d;
  logic [15:0]         addr_q, addr_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [15:0]         widx_q, widx_d;
  logic [23:0]         word_q, word_d;
  logic [7:0]          acc_q, acc_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   maddr_q, maddr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                run_q, run_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [15:0]         words_q, words_d;

  // Writes are at most one per four bytes, so the stream never needs throttling.
  assign in_ready     = 1'b1;
  assign mem_we       = we_q;
  assign mem_addr     = maddr_q;
  assign mem_wdata    = wdata_q;
  assign cpu_run      = run_q;
  assign busy         = busy_q;
  assign load_done    = done_q;
  assign load_err     = err_q;
  assign words_loaded = words_q;

  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    bcnt_d  = bcnt_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    widx_d  = widx_q;
    word_d  = word_q;
    acc_d   = acc_q;
    we_d    = 1'b0;
    maddr_d = maddr_q;
    wdata_d = wdata_q;
    run_d   = run_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    words_d = words_q;
    if (in_valid) begin
      case (state_q)
        S_IDLE, S_RUN: begin
          if (in_data == SYNC_BYTE) begin
            state_d = S_HDR;
            hcnt_d  = 2'd0;
            bcnt_d  = 2'd0;
            widx_d  = 16'd0;
            acc_d   = 8'd0;
            words_d = 16'd0;
            addr_d  = 16'd0;
            cnt_d   = 16'd0;
            busy_d  = 1'b1;
            run_d   = 1'b0;
          end
        end
        S_HDR: begin
          acc_d  = acc_q ^ in_data;
          hcnt_d = hcnt_q + 2'd1;
          case (hcnt_q)
            2'd0:    addr_d = {in_data, addr_q[7:0]};
            2'd1:    addr_d = {addr_q[15:8], in_data};
            2'd2:    cnt_d  = {in_data, cnt_q[7:0]};
            default: begin
              cnt_d   = {cnt_q[15:8], in_data};
              state_d = (cnt_d == 16'd0) ? S_CKS : S_DATA;
            end
          endcase
        end
        S_DATA: begin
          acc_d  = acc_q ^ in_data;
          word_d = {word_q[15:0], in_data};
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            we_d    = 1'b1;
            wdata_d = {word_q, in_data};
            // truncation gives the modulo-2^ADDR_W address wrap
            maddr_d = ADDR_W'(addr_q + widx_q);
            widx_d  = widx_q + 16'd1;
            words_d = widx_q + 16'd1;
            if (widx_q == cnt_q - 16'd1) state_d = S_CKS;
          end
        end
        S_CKS: begin
          busy_d = 1'b0;
          if (in_data == acc_q) begin
            done_d  = 1'b1;
            run_d   = 1'b1;
            state_d = S_RUN;
          end else begin
            err_d   = 1'b1;
            run_d   = 1'b0;
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      hcnt_q  <= 2'd0;
      bcnt_q  <= 2'd0;
      addr_q  <= 16'd0;
      cnt_q   <= 16'd0;
      widx_q  <= 16'd0;
      word_q  <= 24'd0;
      acc_q   <= 8'd0;
      we_q    <= 1'b0;
      maddr_q <= '0;
      wdata_q <= 32'd0;
      run_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      words_q <= 16'd0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      bcnt_q  <= bcnt_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      widx_q  <= widx_d;
      word_q  <= word_d;
      acc_q   <= acc_d;
      we_q    <= we_d;
      maddr_q <= maddr_d;
      wdata_q <= wdata_d;
      run_q   <= run_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      words_q <= words_d;
    end
  end

endmodule

// File: tb/tb_mips_prog_loader.sv
// Scoreboard bench for mips_prog_loader: frame-level model pushes expected writes
// and outcomes; a negedge monitor pops and compares whatever the loader emits.
module tb_mips_prog_loader;

  logic        clk1 = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready, mem_we, cpu_run, busy, load_done, load_err;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [15:0] words_loaded;

  mips_prog_loader #(.ADDR_W(10), .SYNC_BYTE(8'hA5)) dut (
    .clk1(clk1), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .cpu_run(cpu_run), .busy(busy),
    .load_done(load_done), .load_err(load_err), .words_loaded(words_loaded)
  );

  always #5 clk1 = ~clk1;

  typedef struct { logic [9:0] addr; logic [31:0] data; logic [15:0] wl; } wr_t;
  typedef struct { bit err; logic [15:0] wl; } oc_t;

  wr_t wq[$];
  oc_t oq[$];
  int  n_chk = 0;
  int  n_pass = 0;
  int  gap_max = 0;
  bit  exp_run = 1'b0;

  task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Monitor: every strobe from the DUT must match the head of a queue.
  always @(negedge clk1) begin
    if (rst_n) begin
      if (mem_we) begin
        if (wq.size() == 0) chk(1'b0, "unexpected_write", {22'd0, mem_addr}, 32'd0);
        else begin
          wr_t w;
          w = wq.pop_front();
          chk(mem_addr == w.addr, "write_addr", {22'd0, mem_addr}, {22'd0, w.addr});
          chk(mem_wdata == w.data, "write_data", mem_wdata, w.data);
          chk(words_loaded == w.wl, "write_words_loaded", {16'd0, words_loaded}, {16'd0, w.wl});
        end
      end
      if (load_done || load_err) begin
        if (oq.size() == 0) chk(1'b0, "unexpected_outcome", {30'd0, load_done, load_err}, 32'd0);
        else begin
          oc_t o;
          o = oq.pop_front();
          chk(load_err == o.err && load_done == !o.err, "outcome_kind",
              {30'd0, load_done, load_err}, {30'd0, !o.err, o.err});
          chk(cpu_run == !o.err, "outcome_cpu_run", {31'd0, cpu_run}, {31'd0, !o.err});
          chk(busy == 1'b0, "outcome_busy", {31'd0, busy}, 32'd0);
          if (!o.err) chk(words_loaded == o.wl, "done_words_loaded", {16'd0, words_loaded}, {16'd0, o.wl});
        end
      end
      if (cpu_run) chk(!busy, "run_while_busy", {31'd0, busy}, 32'd0);
    end
  end

  task automatic send_byte(input logic [7:0] b);
    repeat ($urandom_range(0, gap_max)) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      @(posedge clk1); #1;
    end
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clk1); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_list(input logic [7:0] bl[$]);
    foreach (bl[i]) send_byte(bl[i]);
  endtask

  // Frame-level reference: writes go to (addr+i) mod 1024, then one outcome.
  task automatic send_frame(input logic [15:0] addr, input logic [31:0] words[$], input bit bad);
    logic [7:0] fb[$];
    logic [7:0] cks;
    int         cnt;
    cnt = words.size();
    fb  = '{8'hA5, addr[15:8], addr[7:0], 8'(cnt >> 8), 8'(cnt)};
    foreach (words[i]) begin
      fb.push_back(words[i][31:24]); fb.push_back(words[i][23:16]);
      fb.push_back(words[i][15:8]);  fb.push_back(words[i][7:0]);
      wq.push_back('{addr: 10'((int'(addr) + i) % 1024), data: words[i], wl: 16'(i + 1)});
    end
    cks = 8'd0;
    for (int i = 1; i < fb.size(); i++) cks ^= fb[i];
    fb.push_back(bad ? (cks ^ 8'h01) : cks);
    oq.push_back('{err: bad, wl: 16'(cnt)});
    exp_run = !bad;
    send_list(fb);
  endtask

  task automatic settle(input string tag);
    repeat (3) @(posedge clk1);
    @(negedge clk1);
    chk(wq.size() == 0, {tag, "_writes_drained"}, wq.size(), 0);
    chk(oq.size() == 0, {tag, "_outcome_seen"}, oq.size(), 0);
    chk(cpu_run == exp_run, {tag, "_cpu_run"}, {31'd0, cpu_run}, {31'd0, exp_run});
    chk(busy == 1'b0, {tag, "_busy"}, {31'd0, busy}, 32'd0);
    wq.delete(); oq.delete();
  endtask

  task automatic check_reset(input string tag);
    chk(in_ready == 1'b1, {tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    chk(mem_we == 1'b0, {tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
    chk(mem_addr == 10'd0, {tag, "_mem_addr"}, {22'd0, mem_addr}, 32'd0);
    chk(mem_wdata == 32'd0, {tag, "_mem_wdata"}, mem_wdata, 32'd0);
    chk(cpu_run == 1'b0, {tag, "_cpu_run"}, {31'd0, cpu_run}, 32'd0);
    chk(busy == 1'b0, {tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk(load_done == 1'b0, {tag, "_load_done"}, {31'd0, load_done}, 32'd0);
    chk(load_err == 1'b0, {tag, "_load_err"}, {31'd0, load_err}, 32'd0);
    chk(words_loaded == 16'd0, {tag, "_words_loaded"}, {16'd0, words_loaded}, 32'd0);
  endtask

  task automatic push_frame1_exp(input bit bad);
    wq.push_back('{addr: 10'h000, data: 32'h280A00C8, wl: 16'd1});
    wq.push_back('{addr: 10'h001, data: 32'h28020001, wl: 16'd2});
    oq.push_back('{err: bad, wl: 16'd2});
    exp_run = !bad;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  f1[$];
    logic [31:0] ws[$];
    f1 = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h02, 8'h28, 8'h0A, 8'h00, 8'hC8,
           8'h28, 8'h02, 8'h00, 8'h01, 8'hC3};

    repeat (2) @(negedge clk1);
    check_reset("reset");
    rst_n = 1'b1;
    @(posedge clk1); #1;

    // Two-word frame with good checksum
    push_frame1_exp(1'b0);
    send_list(f1);
    settle("frame1");

    // Same frame with bad checksum: writes still land, CPU held
    f1[13] = 8'hC2;
    push_frame1_exp(1'b1);
    send_list(f1);
    settle("badcks");
    send_byte(8'h00);
    @(negedge clk1);
    chk(busy == 1'b0 && cpu_run == 1'b0, "idle_discard", {30'd0, busy, cpu_run}, 32'd0);

    // Address wrap at top of memory
    ws = '{32'h11223344, 32'hA5A5A5A5, 32'hDEADBEEF};
    send_frame(16'h03FE, ws, 1'b0);
    settle("wrap");

    // Empty frame
    oq.push_back('{err: 1'b0, wl: 16'd0});
    exp_run = 1'b1;
    send_list('{8'hA5, 8'h00, 8'hC8, 8'h00, 8'h00, 8'hC8});
    settle("cnt0");

    // Junk in RUN is ignored; SYNC starts a reload
    send_byte(8'h12);
    @(negedge clk1);
    chk(cpu_run == 1'b1 && busy == 1'b0, "run_ignore", {30'd0, cpu_run, busy}, 32'd2);
    send_byte(8'hA5);
    @(negedge clk1);
    chk(cpu_run == 1'b0 && busy == 1'b1, "reload_start", {30'd0, cpu_run, busy}, 32'd1);
    f1[13] = 8'hC3;
    push_frame1_exp(1'b0);
    for (int i = 1; i < f1.size(); i++) send_byte(f1[i]);
    settle("reload");

    // Randomized frames with stream gaps and leading junk
    gap_max = 2;
    for (int n = 0; n < 10; n++) begin
      logic [31:0] rw[$];
      int          cnt;
      repeat ($urandom_range(0, 3)) begin
        logic [7:0] j;
        j = 8'($urandom);
        if (j == 8'hA5) j = 8'h5A;
        send_byte(j);
      end
      cnt = $urandom_range(0, 5);
      rw.delete();
      for (int k = 0; k < cnt; k++) rw.push_back($urandom);
      send_frame(16'($urandom), rw, ($urandom_range(0, 3) == 0));
      settle("rand");
    end

    // Reset mid-frame after the sixth data byte
    wq.push_back('{addr: 10'h010, data: 32'h01020304, wl: 16'd1});
    send_list('{8'hA5, 8'h00, 8'h10, 8'h00, 8'h03, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06});
    rst_n = 1'b0;
    @(negedge clk1);
    check_reset("midreset");
    chk(wq.size() == 0, "midreset_word0_written", wq.size(), 0);
    wq.delete(); oq.delete();
    rst_n = 1'b1;
    @(posedge clk1); #1;
    push_frame1_exp(1'b0);
    send_list(f1);
    settle("after_reset");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
